// File: rtl/id_ex_pipeline_register.sv
// ID/EX pipeline register: holds decode-stage operands, immediate, control bits,
// register specifiers, funct and PC+4 for the EX stage; freezes as a unit on a stall.
module id_ex_pipeline_register #(
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int FUNCT_W = 6,
    parameter int ALUOP_W = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               hit,
    input  logic [DATA_W-1:0]  read_data_1,
    input  logic [DATA_W-1:0]  read_data_2,
    input  logic [DATA_W-1:0]  sign_extended_immediate,
    input  logic               RegDst,
    input  logic               ALUSrc,
    input  logic               MemtoReg,
    input  logic               RegWrite,
    input  logic               MemRead,
    input  logic               MemWrite,
    input  logic               Branch,
    input  logic [ALUOP_W-1:0] ALUOp,
    input  logic [REG_W-1:0]   rt,
    input  logic [REG_W-1:0]   rd,
    input  logic [FUNCT_W-1:0] funct,
    input  logic [DATA_W-1:0]  next_PC,
    output logic [DATA_W-1:0]  read_data_1_output,
    output logic [DATA_W-1:0]  read_data_2_output,
    output logic [DATA_W-1:0]  sign_extended_immediate_output,
    output logic               RegDst_output,
    output logic               ALUSrc_output,
    output logic               MemtoReg_output,
    output logic               RegWrite_output,
    output logic               MemRead_output,
    output logic               MemWrite_output,
    output logic               Branch_output,
    output logic [ALUOP_W-1:0] ALUOp_output,
    output logic [REG_W-1:0]   rt_output,
    output logic [REG_W-1:0]   rd_output,
    output logic [FUNCT_W-1:0] funct_output,
    output logic [DATA_W-1:0]  next_PC_output
);

    // Only an explicit 1 captures; an unknown hit holds the stage like a stall.
    logic capture;
    assign capture = (hit === 1'b1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            read_data_1_output             <= '0;
            read_data_2_output             <= '0;
            sign_extended_immediate_output <= '0;
            RegDst_output                  <= 1'b0;
            ALUSrc_output                  <= 1'b0;
            MemtoReg_output                <= 1'b0;
            RegWrite_output                <= 1'b0;
            MemRead_output                 <= 1'b0;
            MemWrite_output                <= 1'b0;
            Branch_output                  <= 1'b0;
            ALUOp_output                   <= '0;
            rt_output                      <= '0;
            rd_output                      <= '0;
            funct_output                   <= '0;
            next_PC_output                 <= '0;
        end else if (capture) begin
            read_data_1_output             <= read_data_1;
            read_data_2_output             <= read_data_2;
            sign_extended_immediate_output <= sign_extended_immediate;
            RegDst_output                  <= RegDst;
            ALUSrc_output                  <= ALUSrc;
            MemtoReg_output                <= MemtoReg;
            RegWrite_output                <= RegWrite;
            MemRead_output                 <= MemRead;
            MemWrite_output                <= MemWrite;
            Branch_output                  <= Branch;
            ALUOp_output                   <= ALUOp;
            rt_output                      <= rt;
            rd_output                      <= rd;
            funct_output                   <= funct;
            next_PC_output                 <= next_PC;
        end
    end

endmodule

// File: tb/tb_id_ex_pipeline_register.sv
// Bench for id_ex_pipeline_register: directed and random steps against a
// whole-record reference (captured record on hit, held otherwise, zero on reset).
module tb_id_ex_pipeline_register;

    typedef struct packed {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic        reg_dst;
        logic        alu_src;
        logic        mem_to_reg;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic [2:0]  alu_op;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  funct;
        logic [31:0] next_pc;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic hit   = 1'b0;
    vec_t drv   = '0;
    vec_t exp_v = '0;
    vec_t obs_v;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] read_data_1_output, read_data_2_output, sign_extended_immediate_output;
    logic        RegDst_output, ALUSrc_output, MemtoReg_output, RegWrite_output;
    logic        MemRead_output, MemWrite_output, Branch_output;
    logic [2:0]  ALUOp_output;
    logic [4:0]  rt_output, rd_output;
    logic [5:0]  funct_output;
    logic [31:0] next_PC_output;

    always #5 clock = ~clock;

    id_ex_pipeline_register dut (
        .clock                          (clock),
        .reset                          (reset),
        .hit                            (hit),
        .read_data_1                    (drv.rd1),
        .read_data_2                    (drv.rd2),
        .sign_extended_immediate        (drv.imm),
        .RegDst                         (drv.reg_dst),
        .ALUSrc                         (drv.alu_src),
        .MemtoReg                       (drv.mem_to_reg),
        .RegWrite                       (drv.reg_write),
        .MemRead                        (drv.mem_read),
        .MemWrite                       (drv.mem_write),
        .Branch                         (drv.branch),
        .ALUOp                          (drv.alu_op),
        .rt                             (drv.rt),
        .rd                             (drv.rd),
        .funct                          (drv.funct),
        .next_PC                        (drv.next_pc),
        .read_data_1_output             (read_data_1_output),
        .read_data_2_output             (read_data_2_output),
        .sign_extended_immediate_output (sign_extended_immediate_output),
        .RegDst_output                  (RegDst_output),
        .ALUSrc_output                  (ALUSrc_output),
        .MemtoReg_output                (MemtoReg_output),
        .RegWrite_output                (RegWrite_output),
        .MemRead_output                 (MemRead_output),
        .MemWrite_output                (MemWrite_output),
        .Branch_output                  (Branch_output),
        .ALUOp_output                   (ALUOp_output),
        .rt_output                      (rt_output),
        .rd_output                      (rd_output),
        .funct_output                   (funct_output),
        .next_PC_output                 (next_PC_output)
    );

    assign obs_v = {read_data_1_output, read_data_2_output, sign_extended_immediate_output,
                    RegDst_output, ALUSrc_output, MemtoReg_output, RegWrite_output,
                    MemRead_output, MemWrite_output, Branch_output, ALUOp_output,
                    rt_output, rd_output, funct_output, next_PC_output};

    task automatic check(input string tag, input logic [153:0] obs, input logic [153:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Drive one record, cross one rising edge, update the reference, check 1 unit later.
    task automatic step(input vec_t v, input logic h, input string tag);
        drv = v;
        hit = h;
        @(posedge clock);
        if (reset) exp_v = '0;
        else if (h === 1'b1) exp_v = v;
        #1;
        check(tag, obs_v, exp_v);
    endtask

    function automatic vec_t rand_vec();
        vec_t v;
        v.rd1        = $urandom;
        v.rd2        = $urandom;
        v.imm        = $urandom;
        v.reg_dst    = 1'($urandom);
        v.alu_src    = 1'($urandom);
        v.mem_to_reg = 1'($urandom);
        v.reg_write  = 1'($urandom);
        v.mem_read   = 1'($urandom);
        v.mem_write  = 1'($urandom);
        v.branch     = 1'($urandom);
        v.alu_op     = 3'($urandom);
        v.rt         = 5'($urandom);
        v.rd         = 5'($urandom);
        v.funct      = 6'($urandom);
        v.next_pc    = $urandom;
        return v;
    endfunction

    vec_t base, ctl, other, saved;

    initial begin
        base        = '0;
        base.rd1    = 32'd111;
        base.rd2    = 32'd222;
        base.imm    = 32'd333;
        base.rt     = 5'd4;
        base.rd     = 5'd5;
        base.funct  = 6'd6;
        base.next_pc = 32'd777;

        #2;
        check("reset_initial", obs_v, '0);
        step(rand_vec(), 1'b1, "reset_held_edge");
        #3 reset = 1'b0;
        @(negedge clock);

        // Capture of a plain vector, field by field.
        step(base, 1'b1, "capture_vec");
        check("capture_rd1", 154'(read_data_1_output), 154'(32'd111));
        check("capture_rd2", 154'(read_data_2_output), 154'(32'd222));
        check("capture_imm", 154'(sign_extended_immediate_output), 154'(32'd333));
        check("capture_rt_rd_funct", 154'({rt_output, rd_output, funct_output}),
              154'({5'd4, 5'd5, 6'd6}));
        check("capture_pc", 154'(next_PC_output), 154'(32'd777));

        // All control bits high, then each one alone to expose cross-coupling.
        ctl = base;
        {ctl.reg_dst, ctl.alu_src, ctl.mem_to_reg, ctl.reg_write,
         ctl.mem_read, ctl.mem_write, ctl.branch} = 7'h7f;
        ctl.alu_op = 3'b101;
        step(ctl, 1'b1, "controls_all");
        check("controls_bits", 154'({RegDst_output, ALUSrc_output, MemtoReg_output,
              RegWrite_output, MemRead_output, MemWrite_output, Branch_output, ALUOp_output}),
              154'({7'h7f, 3'd5}));
        for (int i = 0; i < 7; i++) begin
            ctl = base;
            {ctl.reg_dst, ctl.alu_src, ctl.mem_to_reg, ctl.reg_write,
             ctl.mem_read, ctl.mem_write, ctl.branch} = 7'(1 << i);
            ctl.alu_op = 3'(1 << (i % 3));
            step(ctl, 1'b1, $sformatf("control_single_%0d", i));
        end

        // Stall: vector of the capture test held across three edges of changed inputs.
        step(base, 1'b1, "stall_load");
        other = rand_vec();
        other.rd1 = 32'd999;
        for (int i = 0; i < 3; i++) begin
            step(other, 1'b0, $sformatf("stall_hold_%0d", i));
            check($sformatf("stall_pc_%0d", i), 154'(next_PC_output), 154'(32'd777));
        end
        step(other, 1'b1, "stall_release");
        check("stall_release_rd1", 154'(read_data_1_output), 154'(32'd999));

        // hit pulses between edges must not capture.
        saved = exp_v;
        drv = rand_vec();
        hit = 1'b0;
        #2 hit = 1'b1;
        #2 hit = 1'b0;
        @(posedge clock);
        #1;
        check("hit_glitch", obs_v, saved);

        // Unknown hit behaves as a stall.
        step(rand_vec(), 1'bx, "hit_unknown");

        // Asynchronous reset mid-cycle, then held across an edge with hit=1.
        step(rand_vec(), 1'b1, "pre_reset_load");
        #2 reset = 1'b1;
        #1;
        exp_v = '0;
        check("reset_async", obs_v, '0);
        step(rand_vec(), 1'b1, "reset_priority");
        #2 reset = 1'b0;
        @(negedge clock);
        check("reset_release_no_edge", obs_v, '0);
        step(base, 1'b1, "first_capture_after_reset");

        // Back-to-back captures with a PC stream 4, 8, 12, ...
        for (int i = 1; i <= 12; i++) begin
            other = rand_vec();
            other.next_pc = 32'(4 * i);
            step(other, 1'b1, $sformatf("b2b_%0d", i));
            check($sformatf("b2b_pc_%0d", i), 154'(next_PC_output), 154'(32'(4 * i)));
        end

        // Random mix of capture and stall.
        for (int i = 0; i < 300; i++) begin
            step(rand_vec(), ($urandom_range(0, 3) != 0), $sformatf("random_%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
